// File: rtl/tdm_pkg.sv
// Shared constants for the two-channel TDM demultiplexer.
package tdm_pkg;

  // Default bits per channel word
  localparam int unsigned TDM_WIDTH = 8;

  // FSM state encoding
  localparam logic [0:0] TDM_HUNT = 1'b0;
  localparam logic [0:0] TDM_RUN  = 1'b1;

  // Channel select values carried on slot[0]
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/one_bit_1_2_demux.sv
// One-bit 1:2 demultiplexer, the dual of the 2:1 mux on the transmit side.
// s = 0 steers a to out_a, s = 1 steers a to out_b; the unselected output is 0.
module one_bit_1_2_demux (
  input  logic a,
  input  logic s,
  output logic out_a,
  output logic out_b
);

  logic s_n;

  // Inverter and two AND gates form the steering network
  assign s_n   = ~s;
  assign out_a = a & s_n;
  assign out_b = a & s;

endmodule

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM receive demultiplexer.
// Serial bits are steered by slot parity into two MSB-first shift registers;
// each completed WIDTH-bit word is registered with a one-cycle valid pulse.
// Optional: define TDM_DEMUX_SYNC_ERR_EN to add the sync_err resync pulse port.
module tdm_demux_2ch
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] out_a,
  output logic             a_valid,
  output logic [WIDTH-1:0] out_b,
  output logic             b_valid
`ifdef TDM_DEMUX_SYNC_ERR_EN
  ,
  output logic             sync_err
`endif
);

  localparam int unsigned SW = $clog2(2 * WIDTH);
  localparam logic [SW-1:0] SLOT_A_DONE = SW'(2 * WIDTH - 2);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(2 * WIDTH - 1);

  logic [0:0]       state;
  logic [SW-1:0]    slot;
  logic [WIDTH-2:0] shift_a;
  logic [WIDTH-2:0] shift_b;

  logic          start;
  logic          resync;
  logic          accept;
  logic          ch_sel;
  logic [SW-1:0] cur_slot;
  logic          bit_a;
  logic          bit_b;

  // Classify the incoming bit: a marker restarts the frame at slot 0,
  // so the effective slot for this bit may differ from the counter.
  always_comb begin
    start    = 1'b0;
    resync   = 1'b0;
    accept   = 1'b0;
    start    = in_valid && frame && ((state == TDM_HUNT) || (slot != '0));
    resync   = in_valid && frame && (state == TDM_RUN) && (slot != '0);
    accept   = in_valid && ((state == TDM_RUN) || frame);
    ch_sel   = start ? CH_A : slot[0];
    cur_slot = start ? '0 : slot;
  end

  one_bit_1_2_demux u_demux (
    .a     (in),
    .s     (ch_sel),
    .out_a (bit_a),
    .out_b (bit_b)
  );

  // FSM, slot counter, shift registers and word output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TDM_HUNT;
      slot    <= '0;
      shift_a <= '0;
      shift_b <= '0;
      out_a   <= '0;
      out_b   <= '0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      if (accept) begin
        state <= TDM_RUN;
        // A marker discards both partial words; the marker bit itself
        // becomes the first A bit of the new frame.
        if (start) begin
          shift_a <= (WIDTH-1)'(bit_a);
          shift_b <= '0;
        end else if (ch_sel == CH_A) begin
          shift_a <= (WIDTH-1)'({shift_a, bit_a});
        end else begin
          shift_b <= (WIDTH-1)'({shift_b, bit_b});
        end
        if (cur_slot == SLOT_A_DONE) begin
          out_a   <= {shift_a, bit_a};
          a_valid <= 1'b1;
        end
        if (cur_slot == SLOT_LAST) begin
          out_b   <= {shift_b, bit_b};
          b_valid <= 1'b1;
        end
        slot <= (cur_slot == SLOT_LAST) ? '0 : cur_slot + 1'b1;
      end
    end
  end

`ifdef TDM_DEMUX_SYNC_ERR_EN
  // One-cycle pulse when a marker arrives away from slot 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= resync;
    end
  end
`endif

endmodule

// File: doc/tdm_demux_2ch.md
# tdm_demux_2ch

Two-channel time-division demultiplexer: the receive end of a 1-bit TDM link whose transmit side interleaves two channels through the 2:1 mux select line. Consumes a serial bit stream with a frame marker, steers even slots to channel A and odd slots to channel B, and deserializes each channel into a WIDTH-bit word, MSB first. Each word is presented with a one-cycle valid pulse. Sits between the serial link pins and the per-channel word consumers.

## Interface
- WIDTH, 8: bits per channel word; frame length is 2*WIDTH valid bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  `in` carries a bit this cycle.
- frame  input  1  qualified by `in_valid`; marks the bit as slot 0 (first bit of channel A's MSB).
- out_a  output  WIDTH  last completed channel A word.
- a_valid  output  1  one-cycle pulse when `out_a` updates.
- out_b  output  WIDTH  last completed channel B word.
- b_valid  output  1  one-cycle pulse when `out_b` updates.
- sync_err  output  1  one-cycle pulse on mid-frame resync; present only with TDM_DEMUX_SYNC_ERR_EN.

## Operation
- States: HUNT (reset state) and RUN. Slot counter `slot`, range 0..2*WIDTH-1; slot[0] selects the channel (0 = A, 1 = B).
- HUNT: a bit with in_valid=1 and frame=0 is dropped. A bit with in_valid=1 and frame=1 is taken as slot 0 and moves the block to RUN, with slot becoming 1.
- RUN: each valid bit shifts into the shift register selected by slot[0], MSB first, then slot increments. After slot 2*WIDTH-1, slot wraps to 0 and the block stays in RUN.
- Free-running: frame is not required at slot 0. frame=1 at slot 0 is accepted silently.
- Resync: if frame=1 and in_valid=1 while slot≠0, both partial shift registers are cleared. The bit is taken as slot 0, and sync_err pulses when the macro is enabled. out_a and out_b are not disturbed.
- Word completion:
  - The bit at slot 2*WIDTH-2 completes A: out_a loads {shift_a, in} and a_valid pulses.
  - The bit at slot 2*WIDTH-1 completes B: out_b loads {shift_b, in} and b_valid pulses.
- in_valid=0: all state holds. frame is ignored without in_valid.
- Reset: out_a=0, out_b=0, a_valid=0, b_valid=0, sync_err=0, shift registers cleared, slot=0, state=HUNT.
- Reset asserted mid-frame: the partial words are discarded, and the block must see a new frame marker before accepting data.

## Timing
- All outputs are registered. Latency is 1 cycle: the valid pulse and the word update appear on the clock edge after the edge that samples the completing bit.
- a_valid and b_valid are never high in the same cycle. They are high for exactly one cycle per completed word.
- Back-to-back valid bits are accepted every cycle, so throughput is 1 bit/clk.
- sync_err is asserted in the cycle after the offending bit is sampled. Its reset value is 0.

## Configuration
- TDM_DEMUX_SYNC_ERR_EN defined: the sync_err port and its pulse register are present.
- TDM_DEMUX_SYNC_ERR_EN undefined: the sync_err port is absent. Resync behaviour is identical, with no indication.

## Structure
- Shared package `tdm_pkg`:
  - state encoding constants TDM_HUNT=0 and TDM_RUN=1;
  - the default word width TDM_WIDTH=8;
  - channel select constants CH_A=0 and CH_B=1.
- Sub-module `one_bit_1_2_demux` (ports a, s, out_a, out_b): a gate-level steering of `in` to channel A or B by slot[0]. It is built from the existing not/and gate cells and forms the dual of the 2:1 mux.
- Top level holds the FSM, the slot counter, the two shift registers and the output registers.

## Test plan
- Basic frame, WIDTH=8: after reset, send 16 valid bits with frame=1 on bit 0, interleaving A=0xA5 and B=0x3C, MSB first. Required: a_valid one cycle after bit 14 with out_a=0xA5, then b_valid one cycle after bit 15 with out_b=0x3C.
- Pre-sync drop: send 5 valid bits with frame=0 in HUNT, then a frame carrying A=0xFF, B=0x00. Required: no valid pulses before the frame; out_a=0xFF, out_b=0x00.
- Gaps and free-running: the same frame with in_valid=0 inserted every third cycle, then a second frame with no frame marker carrying A=0x12, B=0x34. Required: out_a is 0xA5 then 0x12, out_b is 0x3C then 0x34, with no extra pulses.
- Mid-frame resync: frame=1 at slot 6, followed by a full A=0x81, B=0x7E frame. Required: sync_err pulses once (macro on); out_a=0x81 and out_b=0x7E; previous out_a/out_b values are held until then.
- Reset mid-frame: assert reset after 9 bits, release, then send 7 bits with frame=0. Required: all outputs are 0 and no valid pulses occur.
- Macro off: rerun the mid-frame resync case. Required: identical out_a/out_b/valid behaviour and no sync_err port.
